// File: rtl/bsg_wormhole_assembler_pkg.sv
// ============================================================================
// bsg_wormhole_assembler_pkg
// Shared FSM encoding, header struct macro and width helper for the assembler.
// Revision: 1.0
// ============================================================================
`default_nettype none

`define DECLARE_BSG_WORMHOLE_HDR_S(cord_width_p, len_width_p) \
    typedef struct packed {                                     \
        logic [len_width_p-1:0]  len;                           \
        logic [cord_width_p-1:0] cord;                          \
    } bsg_wormhole_hdr_s

package bsg_wormhole_assembler_pkg;

    typedef enum logic [1:0] {
        eHdr  = 2'd0,
        eBody = 2'd1,
        eFull = 2'd2
    } state_e;

    function automatic int pkt_width(input int flit_width, input int len_width);
        return flit_width * (1 << len_width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_counter_clear_up.sv
// ============================================================================
// bsg_counter_clear_up
// Up counter with synchronous clear; clear and up together load 1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bsg_counter_clear_up #(
    parameter int WIDTH_P = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [WIDTH_P-1:0] count_o
);

    logic [WIDTH_P-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= WIDTH_P'(up_i);
        end else if (up_i) begin
            r_count <= r_count + WIDTH_P'(1);
        end
    end

    assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/bsg_wormhole_packet_assembler.sv
// ============================================================================
// bsg_wormhole_packet_assembler
// Collects a header plus len body flits into one wide word, offered via v/ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bsg_wormhole_packet_assembler
    import bsg_wormhole_assembler_pkg::*;
#(
    parameter  int FLIT_WIDTH_P = 8,
    parameter  int CORD_WIDTH_P = 5,
    parameter  int LEN_WIDTH_P  = 3,
    localparam int MAX_FLITS_LP = 1 << LEN_WIDTH_P,
    localparam int PKT_WIDTH_LP = pkt_width(FLIT_WIDTH_P, LEN_WIDTH_P)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [FLIT_WIDTH_P-1:0] data_i,
    input  logic                    v_i,
    output logic                    ready_and_o,
    output logic [PKT_WIDTH_LP-1:0] data_o,
    output logic [LEN_WIDTH_P-1:0]  len_o,
    output logic [CORD_WIDTH_P-1:0] cord_o,
    output logic                    v_o,
    input  logic                    ready_and_i
);

    localparam int IDX_WIDTH = LEN_WIDTH_P + 1;

    `DECLARE_BSG_WORMHOLE_HDR_S(CORD_WIDTH_P, LEN_WIDTH_P);

    state_e                 r_state;
    state_e                 w_state_next;
    bsg_wormhole_hdr_s      r_hdr;
    bsg_wormhole_hdr_s      w_hdr_in;
    logic [IDX_WIDTH-1:0]   r_index;
    logic                   w_accept;
    logic                   w_hdr_load;
    logic                   w_body_acc;
    logic                   w_last_body;

    assign w_hdr_in    = bsg_wormhole_hdr_s'(data_i[CORD_WIDTH_P+LEN_WIDTH_P-1:0]);
    assign w_accept    = v_i & ready_and_o;
    // In eFull an accepted flit is always the next header, taken while draining.
    assign w_hdr_load  = w_accept & (r_state != eBody);
    assign w_body_acc  = w_accept & (r_state == eBody);
    assign w_last_body = w_body_acc & (r_index == {1'b0, r_hdr.len});

    // The last body flit does not advance the index so it stays within len.
    bsg_counter_clear_up #(
        .WIDTH_P (IDX_WIDTH)
    ) u_index (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (w_hdr_load),
        .up_i      (w_hdr_load | (w_body_acc & ~w_last_body)),
        .count_o   (r_index)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= eHdr;
            r_hdr   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_hdr_load) begin
                r_hdr <= w_hdr_in;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            eHdr: begin
                if (w_hdr_load) begin
                    w_state_next = (w_hdr_in.len == '0) ? eFull : eBody;
                end
            end
            eBody: begin
                if (w_last_body) begin
                    w_state_next = eFull;
                end
            end
            eFull: begin
                if (ready_and_i) begin
                    if (w_hdr_load) begin
                        w_state_next = (w_hdr_in.len == '0) ? eFull : eBody;
                    end else begin
                        w_state_next = eHdr;
                    end
                end
            end
            default: w_state_next = eHdr;
        endcase
    end

    always_comb begin
        ready_and_o = 1'b0;
        v_o         = 1'b0;
        unique case (r_state)
            eHdr, eBody: begin
                ready_and_o = reset_n_i;
            end
            eFull: begin
                ready_and_o = reset_n_i & ready_and_i;
                v_o         = 1'b1;
            end
            default: begin
                ready_and_o = 1'b0;
                v_o         = 1'b0;
            end
        endcase
    end

    // Header load zeroes every slot so no earlier body bytes survive.
    for (genvar k = 0; k < MAX_FLITS_LP; k++) begin : g_slot
        logic [FLIT_WIDTH_P-1:0] r_slot;

        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                r_slot <= '0;
            end else if (w_hdr_load) begin
                r_slot <= (k == 0) ? data_i : '0;
            end else if (w_body_acc && (r_index == IDX_WIDTH'(k))) begin
                r_slot <= data_i;
            end
        end

        assign data_o[k*FLIT_WIDTH_P +: FLIT_WIDTH_P] = r_slot;
    end

    assign len_o  = r_hdr.len;
    assign cord_o = r_hdr.cord;

    a_v_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (v_o && !ready_and_i) |=> v_o);

    a_data_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (v_o && !ready_and_i) |=> $stable(data_o));

    a_index_max: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        r_index <= IDX_WIDTH'(MAX_FLITS_LP - 1));

endmodule

`default_nettype wire

// File: tb/tb_bsg_wormhole_packet_assembler.sv
// ============================================================================
// tb_bsg_wormhole_packet_assembler
// Scoreboard bench: expected packets queued at issue, popped on each handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bsg_wormhole_packet_assembler;

    logic        clk_i       = 1'b0;
    logic        reset_n_i   = 1'b0;
    logic [7:0]  data_i      = 8'h00;
    logic        v_i         = 1'b0;
    logic        ready_and_o;
    logic [63:0] data_o;
    logic [2:0]  len_o;
    logic [4:0]  cord_o;
    logic        v_o;
    logic        ready_and_i = 1'b0;

    typedef struct packed {
        logic [63:0] d;
        logic [2:0]  l;
        logic [4:0]  c;
    } exp_t;

    exp_t exp_q[$];
    int   n_total    = 0;
    int   n_pass     = 0;
    int   ready_mode = 0;

    always #5 clk_i = ~clk_i;

    bsg_wormhole_packet_assembler dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .data_i      (data_i),
        .v_i         (v_i),
        .ready_and_o (ready_and_o),
        .data_o      (data_o),
        .len_o       (len_o),
        .cord_o      (cord_o),
        .v_o         (v_o),
        .ready_and_i (ready_and_i)
    );

    function automatic void check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endfunction

    // Packet = header byte at offset 0, body byte i at offset i+1, zeros above.
    function automatic exp_t model(input logic [7:0] hdr, input logic [7:0] body [0:6]);
        exp_t e;
        int   n;
        n   = int'(hdr[7:5]);
        e.l = hdr[7:5];
        e.c = hdr[4:0];
        e.d = 64'(hdr);
        for (int i = 0; i < n; i++) e.d = e.d | (64'(body[i]) << (8 * (i + 1)));
        return e;
    endfunction

    always @(posedge clk_i) begin
        #2;
        case (ready_mode)
            0:       ready_and_i = 1'b1;
            1:       ready_and_i = 1'b0;
            default: ready_and_i = 1'($urandom_range(0, 1));
        endcase
    end

    bit          held = 1'b0;
    logic [63:0] held_data;
    always @(negedge clk_i) begin
        exp_t e;
        if (!reset_n_i) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check_eq("hold_v_o", 64'(v_o), 64'd1);
                check_eq("hold_data_o", data_o, held_data);
            end
            if (v_o && ready_and_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_pkt_queue_size", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("pkt_data_o", data_o, e.d);
                    check_eq("pkt_len_o", 64'(len_o), 64'(e.l));
                    check_eq("pkt_cord_o", 64'(cord_o), 64'(e.c));
                end
            end
            held      = v_o && !ready_and_i;
            held_data = data_o;
        end
    end

    task automatic send_flit(input logic [7:0] d, input bit gap, output int waited);
        waited = 0;
        v_i    = 1'b1;
        data_i = d;
        forever begin
            @(negedge clk_i);
            if (ready_and_o) break;
            waited++;
            if (waited > 2000) begin
                check_eq("flit_accept_timeout", 64'(waited), 64'd0);
                break;
            end
        end
        @(posedge clk_i); #1;
        v_i    = 1'b0;
        data_i = 8'($urandom);
        if (gap) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic send_packet(input logic [7:0] hdr, input logic [7:0] body [0:6],
                               input bit gap, output int hdr_wait);
        int w;
        exp_q.push_back(model(hdr, body));
        send_flit(hdr, gap, hdr_wait);
        for (int i = 0; i < int'(hdr[7:5]); i++) send_flit(body[i], gap, w);
    endtask

    task automatic wait_drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 5000) begin
            @(negedge clk_i);
            c++;
        end
        check_eq("drain_queue_size", 64'(exp_q.size()), 64'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        int         w;
        logic [7:0] b [0:6];
        logic [7:0] hdr;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_held_ready_and_o", 64'(ready_and_o), 64'd0);
        check_eq("rst_held_v_o", 64'(v_o), 64'd0);
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check_eq("rst_ready_and_o", 64'(ready_and_o), 64'd1);
        check_eq("rst_v_o", 64'(v_o), 64'd0);
        check_eq("rst_data_o", data_o, 64'd0);
        check_eq("rst_len_cord", 64'({len_o, cord_o}), 64'd0);
        @(posedge clk_i); #1;

        b = '{8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_packet(8'h43, b, 1'b0, w);
        @(negedge clk_i);
        check_eq("p43_latency_v_o", 64'(v_o), 64'd1);
        check_eq("p43_data_o", data_o, 64'h0000_0000_00BB_AA43);
        @(posedge clk_i); #1;

        b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_packet(8'h05, b, 1'b0, w);
        @(negedge clk_i);
        check_eq("p05_v_o", 64'(v_o), 64'd1);
        check_eq("p05_data_o", data_o, 64'h05);
        check_eq("p05_len_o", 64'(len_o), 64'd0);
        check_eq("p05_cord_o", 64'(cord_o), 64'd5);
        @(posedge clk_i); #1;

        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        send_packet(8'hE1, b, 1'b0, w);
        @(negedge clk_i);
        check_eq("pE1_data_o", data_o, 64'h0706_0504_0302_01E1);
        @(posedge clk_i); #1;
        wait_drain();

        ready_mode = 1;
        b = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_packet(8'h23, b, 1'b0, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check_eq("stall_v_o", 64'(v_o), 64'd1);
            check_eq("stall_data_o", data_o, 64'h5A23);
            check_eq("stall_ready_and_o", 64'(ready_and_o), 64'd0);
        end
        @(posedge clk_i); #1;
        ready_mode = 0;
        b = '{8'h9C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_packet(8'h20, b, 1'b0, w);
        check_eq("drain_hdr_same_cycle_wait", 64'(w), 64'd0);
        @(negedge clk_i);
        check_eq("no_bubble_v_o", 64'(v_o), 64'd1);
        check_eq("no_bubble_data_o", data_o, 64'h9C20);
        @(posedge clk_i); #1;
        wait_drain();

        send_flit(8'h62, 1'b0, w);
        send_flit(8'hFF, 1'b0, w);
        reset_n_i = 1'b0;
        @(negedge clk_i);
        check_eq("midrst_ready_and_o", 64'(ready_and_o), 64'd0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check_eq("midrst_v_o", 64'(v_o), 64'd0);
        check_eq("midrst_data_o", data_o, 64'd0);
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        b = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_packet(8'h21, b, 1'b0, w);
        @(negedge clk_i);
        check_eq("postrst_v_o", 64'(v_o), 64'd1);
        check_eq("postrst_data_o", data_o, 64'h1121);
        check_eq("postrst_len_cord", 64'({len_o, cord_o}), 64'({3'd1, 5'd1}));
        @(posedge clk_i); #1;
        wait_drain();

        ready_mode = 2;
        for (int i = 0; i < 100; i++) begin
            hdr = {3'(i % 8), 5'($urandom)};
            for (int j = 0; j < 7; j++) b[j] = 8'($urandom);
            send_packet(hdr, b, 1'b1, w);
        end
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: got %0d checks done, required bench completion", n_total);
        $fatal(1);
    end

endmodule

`default_nettype wire
